// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request/response bus between datapath and data memory
interface data_mem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Addr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        MemReady;
    logic        MemBusy;
    logic        MemErr;

    modport master (
        output MemRead, MemWrite, Addr, WriteData,
        input  ReadData, MemReady, MemBusy, MemErr
    );

    modport slave (
        input  MemRead, MemWrite, Addr, WriteData,
        output ReadData, MemReady, MemBusy, MemErr
    );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency word data memory with MemReady pulse (option: DMEM_ALIGN_CHECK_EN)
module data_mem_responder #(
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    data_mem_responder_if.slave  bus
);
    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [31:0]      wdata_q, wdata_d;
    logic             is_write_q, is_write_d;
    logic             err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             ready_q, ready_d;
    logic             busy_q, busy_d;
    logic             err_out_q, err_out_d;
    logic             req;
    logic             bad_align;

    logic [31:0] mem [DEPTH];

    // Upper address bits wrap; low bits only matter when alignment checking is built in.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.Addr[31:IDX_W+2], bus.Addr[1:0]};

    assign req = bus.MemRead | bus.MemWrite;

`ifdef DMEM_ALIGN_CHECK_EN
    assign bad_align = (bus.Addr[1:0] != 2'b00);
`else
    assign bad_align = 1'b0;
`endif

    // State, latched request and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            is_write_q <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= 32'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
            err_out_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            wdata_q    <= wdata_d;
            is_write_q <= is_write_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            err_out_q  <= err_out_d;
        end
    end

    // Next state, request latch and next output values.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        wdata_d    = wdata_q;
        is_write_d = is_write_q;
        err_d      = err_q;
        rdata_d    = 32'd0;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    idx_d      = bus.Addr[IDX_W+1:2];
                    wdata_d    = bus.WriteData;
                    is_write_d = bus.MemWrite;
                    err_d      = (bus.MemRead & bus.MemWrite) | bad_align;
                    cnt_d      = WAIT_INIT;
                    state_d    = (WAIT_CYCLES > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d   = (state_d == S_RESP);
        busy_d    = (state_d != S_IDLE);
        err_out_d = (state_d == S_RESP) && err_d;
        if ((state_d == S_RESP) && !is_write_d && !err_d) begin
            rdata_d = mem[idx_d];
        end
    end

    // Store commits on the edge that ends the response cycle; reset drops it.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == S_RESP) && is_write_q && !err_q) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.ReadData = rdata_q;
    assign bus.MemReady = ready_q;
    assign bus.MemBusy  = busy_q;
    assign bus.MemErr   = err_out_q;
endmodule
